ser_collect: RTL

- Receive-side companion to the serial adder. Shifts in the LSB-first serial sum stream and reassembles it into a parallel WIDTH-bit word.
- Uses the same mode/load protocol and clock as the adder: mode=1 is the load cycle, mode=0 is a shift cycle.
- Sits directly on the adder's sum output. Presents the parallel result with a valid flag to downstream logic or benches.

---
 rtl/ser_collect.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ser_collect.sv
// ============================================================================
// Module   : ser_collect
// Purpose  : Receive-side companion to the serial adder. Shifts in the
//            LSB-first serial sum stream and reassembles it into a parallel
//            WIDTH-bit word with a valid flag.
//
// Ports    : clk      - system clock, rising edge
//            reset    - asynchronous active-high reset
//            mode     - 1 = load/start (same cycle the adder loads), 0 = shift
//            sum_in   - serial sum bit from the adder, LSB first
//            result   - assembled word
//            valid    - result complete and stable
//            busy     - collection in progress
//            bit_cnt  - number of bits captured so far
//            op_a/op_b, mismatch - only with SER_COLLECT_CHECK_EN
//
// Option   : `define SER_COLLECT_CHECK_EN to add the op_a/op_b inputs and a
//            mismatch flag comparing the assembled word to op_a + op_b.
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_collect #(
  parameter int WIDTH = 16,
  // Derived from WIDTH; not meant to be overridden.
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             sum_in,
`ifdef SER_COLLECT_CHECK_EN
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             mismatch,
`endif
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Count value held while the final (WIDTH-th) bit is being captured.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      result  <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      result  <= result_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // A load (mode=1) wins from every state and discards any partial word;
  // sum_in is deliberately ignored on that edge because the adder is only
  // loading its operands then.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    result_nxt = result;
    cnt_nxt    = bit_cnt;

    if (mode) begin
      state_nxt  = SHIFT;
      result_nxt = '0;
      cnt_nxt    = '0;
    end else begin
      case (state)
        SHIFT: begin
          // New bit enters the MSB; after WIDTH shifts the first bit
          // received has walked down to result[0].
          result_nxt = {sum_in, result[WIDTH-1:1]};
          cnt_nxt    = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_CNT) begin
            state_nxt = DONE;
          end
        end
        IDLE,
        DONE: begin
          // Hold: extra shift edges (e.g. a carry-out cycle) are dropped,
          // so the sum wraps modulo 2^WIDTH.
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign valid = (state == DONE);
  assign busy  = (state == SHIFT);

`ifdef SER_COLLECT_CHECK_EN
  // --------------------------------------------------------------------------
  // Self-check: the expected sum is captured on the load edge so later
  // changes on op_a/op_b do not disturb the comparison.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] expected;
  logic             capture_done;

  assign capture_done = !mode && (state == SHIFT) && (bit_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected <= '0;
      mismatch <= 1'b0;
    end else if (mode) begin
      expected <= op_a + op_b;
      mismatch <= 1'b0;
    end else if (capture_done) begin
      mismatch <= (result_nxt != expected);
    end
  end
`endif

endmodule

`default_nettype wire
